// File: rtl/fg_pkg.sv
// Purpose: shared types and constants for the function-generator configuration path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fg_pkg;

  localparam int FW = 32;

  localparam logic [FW-1:0] FREQ_DEFAULT_W = 32'd1789;
  localparam logic [FW-1:0] FREQ_MIN_W     = 32'd179;
  localparam logic [FW-1:0] FREQ_MAX_W     = 32'd178956970;

  // Tuning-word increments indexed by Step_sel (entry 0 is the finest step).
  localparam logic [3:0][FW-1:0] STEP_TBL = {32'd178957, 32'd17896, 32'd1790, 32'd179};

  typedef enum logic [1:0] {SINE, SQUARE, TRIANGLE, SAW} wave_t;
  typedef enum logic [1:0] {INIT, IDLE, APPLY, SEND} state_t;
  typedef enum logic [1:0] {OP_WAVE, OP_STEP, OP_UP, OP_DOWN} op_t;

endpackage

// File: rtl/fg_sat_step.sv
// Purpose: saturating add/subtract of a frequency step, clamped to [min, max].
// Latency: combinational.
// Backpressure: none.
// Ports: value/step/min/max in (FW bits), dir in (0 add, 1 subtract), result out.
module fg_sat_step #(
  parameter int FW = 32
) (
  input  logic [FW-1:0] value,
  input  logic [FW-1:0] step,
  input  logic          dir,
  input  logic [FW-1:0] min,
  input  logic [FW-1:0] max,
  output logic [FW-1:0] result
);

  // Thresholds are compared before the add/sub so no intermediate ever wraps;
  // this relies on min + step <= max for every legal step.
  always_comb begin
    result = value;
    if (dir) begin
      result = (value < min + step) ? min : value - step;
    end else begin
      result = (value > max - step) ? max : value + step;
    end
  end

endmodule

// File: rtl/fg_cfg_sequencer.sv
// Purpose: turns debounced button pulses into DDS waveform/frequency configuration updates.
// Latency: pulse sampled at edge k -> Cfg_valid high after edge k+2 when idle.
// Backpressure: Cfg_valid holds with stable config until Cfg_ready; new presses wait as pending bits.
// Ports: Fg_clk, Resetn (async, active-low); Btn_wave/Btn_step/Btn_up/Btn_down pulses in;
//        Cfg_ready in; Cfg_valid, Wave_sel, Freq_word out to the DDS core; Step_sel, Busy status out.
module fg_cfg_sequencer
  import fg_pkg::*;
#(
  parameter int           FW           = fg_pkg::FW,
  parameter logic [FW-1:0] FREQ_DEFAULT = FREQ_DEFAULT_W,
  parameter logic [FW-1:0] FREQ_MIN     = FREQ_MIN_W,
  parameter logic [FW-1:0] FREQ_MAX     = FREQ_MAX_W,
  parameter logic [FW-1:0] STEP0        = STEP_TBL[0],
  parameter logic [FW-1:0] STEP1        = STEP_TBL[1],
  parameter logic [FW-1:0] STEP2        = STEP_TBL[2],
  parameter logic [FW-1:0] STEP3        = STEP_TBL[3]
) (
  input  logic          Fg_clk,
  input  logic          Resetn,
  input  logic          Btn_wave,
  input  logic          Btn_step,
  input  logic          Btn_up,
  input  logic          Btn_down,
  input  logic          Cfg_ready,
  output logic          Cfg_valid,
  output logic [1:0]    Wave_sel,
  output logic [FW-1:0] Freq_word,
  output logic [1:0]    Step_sel,
  output logic          Busy
);

  localparam logic [3:0][FW-1:0] STEPS = {STEP3, STEP2, STEP1, STEP0};

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [3:0]    pending_q;   // bit order matches op_t: wave, step, up, down
  logic [3:0]    pend_clr;
  logic [3:0]    pend_set;
  wave_t         wave_q;
  logic [1:0]    step_q;
  logic [FW-1:0] freq_q;
  logic [FW-1:0] freq_next;

  assign pend_set = {Btn_down, Btn_up, Btn_step, Btn_wave};

  fg_sat_step #(.FW(FW)) u_sat (
    .value  (freq_q),
    .step   (STEPS[step_q]),
    .dir    (op_q == OP_DOWN),
    .min    (FREQ_MIN),
    .max    (FREQ_MAX),
    .result (freq_next)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pend_clr = 4'b0000;
    case (state_q)
      INIT: state_d = SEND;
      IDLE: begin
        // Fixed priority: lowest bit index wins (wave > step > up > down).
        if (pending_q[0]) begin
          op_d = OP_WAVE; pend_clr = 4'b0001; state_d = APPLY;
        end else if (pending_q[1]) begin
          op_d = OP_STEP; pend_clr = 4'b0010; state_d = APPLY;
        end else if (pending_q[2]) begin
          op_d = OP_UP;   pend_clr = 4'b0100; state_d = APPLY;
        end else if (pending_q[3]) begin
          op_d = OP_DOWN; pend_clr = 4'b1000; state_d = APPLY;
        end
      end
      APPLY: state_d = (op_q == OP_STEP) ? IDLE : SEND;
      SEND:  if (Cfg_ready) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= INIT;
      op_q      <= OP_WAVE;
      pending_q <= 4'b0000;
      wave_q    <= SINE;
      step_q    <= 2'd0;
      freq_q    <= FREQ_DEFAULT;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      // A new press on the same edge as its clear keeps the bit set.
      pending_q <= (pending_q & ~pend_clr) | pend_set;
      if (state_q == APPLY) begin
        case (op_q)
          OP_WAVE: wave_q <= wave_t'(wave_q + 2'd1);
          OP_STEP: step_q <= step_q + 2'd1;
          default: freq_q <= freq_next;
        endcase
      end
    end
  end

  assign Cfg_valid = (state_q == SEND);
  assign Busy      = (state_q != IDLE);
  assign Wave_sel  = wave_q;
  assign Step_sel  = step_q;
  assign Freq_word = freq_q;

endmodule

// File: tb/tb_fg_cfg_sequencer.sv
// Purpose: directed self-checking bench for fg_cfg_sequencer.
// Latency: n/a.
// Backpressure: Cfg_ready driven by the bench to stall and release SEND.
module tb_fg_cfg_sequencer;

  localparam logic [31:0] FMAX = 32'd178956970;

  logic        Fg_clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        Btn_wave = 1'b0, Btn_step = 1'b0, Btn_up = 1'b0, Btn_down = 1'b0;
  logic        Cfg_ready = 1'b1;
  logic        Cfg_valid;
  logic [1:0]  Wave_sel;
  logic [31:0] Freq_word;
  logic [1:0]  Step_sel;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;
  int snap;
  logic held;

  fg_cfg_sequencer dut (
    .Fg_clk    (Fg_clk),
    .Resetn    (Resetn),
    .Btn_wave  (Btn_wave),
    .Btn_step  (Btn_step),
    .Btn_up    (Btn_up),
    .Btn_down  (Btn_down),
    .Cfg_ready (Cfg_ready),
    .Cfg_valid (Cfg_valid),
    .Wave_sel  (Wave_sel),
    .Freq_word (Freq_word),
    .Step_sel  (Step_sel),
    .Busy      (Busy)
  );

  always #5 Fg_clk = ~Fg_clk;

  // Counts every cycle in which a configuration is offered.
  always @(negedge Fg_clk) if (Cfg_valid) vld_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Fg_clk);
    #1;
  endtask

  // One button pulse (0 wave, 1 step, 2 up, 3 down) then run to idle with Cfg_ready high.
  task automatic op(input int b);
    Btn_wave = (b == 0);
    Btn_step = (b == 1);
    Btn_up   = (b == 2);
    Btn_down = (b == 3);
    tick();
    Btn_wave = 0; Btn_step = 0; Btn_up = 0; Btn_down = 0;
    tick();
    tick();
    if (Cfg_valid) tick();
  endtask

  initial begin
    // 1. reset values and power-up push
    Cfg_ready = 1;
    repeat (2) @(posedge Fg_clk);
    #1;
    chk("rst_valid", Cfg_valid, 0);
    chk("rst_busy", Busy, 1);
    chk("rst_wave", Wave_sel, 0);
    chk("rst_freq", Freq_word, 1789);
    chk("rst_step", Step_sel, 0);
    Resetn = 1;
    tick();
    chk("init_valid", Cfg_valid, 1);
    chk("init_wave", Wave_sel, 0);
    chk("init_freq", Freq_word, 1789);
    tick();
    chk("init_valid_drop", Cfg_valid, 0);
    chk("init_busy", Busy, 0);

    // 2. up with stalled ready
    Cfg_ready = 0;
    Btn_up = 1;
    tick();
    Btn_up = 0;
    tick();
    chk("up_apply_valid", Cfg_valid, 0);
    tick();
    chk("up_valid", Cfg_valid, 1);
    chk("up_freq", Freq_word, 1968);
    held = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!Cfg_valid || Freq_word != 32'd1968) held = 0;
    end
    chk("up_hold", held, 1);
    Cfg_ready = 1;
    tick();
    chk("up_hs_valid", Cfg_valid, 0);
    chk("up_hs_busy", Busy, 0);
    tick();
    chk("ready_idle_nofx", Busy, 0);

    // restart from defaults
    Resetn = 0;
    tick();
    Resetn = 1;
    tick();
    tick();

    // 3. wave and down in the same cycle
    Btn_wave = 1; Btn_down = 1;
    tick();
    Btn_wave = 0; Btn_down = 0;
    tick();
    tick();
    chk("wd1_valid", Cfg_valid, 1);
    chk("wd1_wave", Wave_sel, 1);
    chk("wd1_freq", Freq_word, 1789);
    tick();
    chk("wd_gap1", Cfg_valid, 0);
    tick();
    chk("wd_gap2", Cfg_valid, 0);
    tick();
    chk("wd2_valid", Cfg_valid, 1);
    chk("wd2_wave", Wave_sel, 1);
    chk("wd2_freq", Freq_word, 1610);
    tick();
    chk("wd2_done", Busy, 0);

    // 4. step cycling without transactions
    snap = vld_cnt;
    for (int i = 0; i < 4; i++) begin
      Btn_step = 1;
      tick();
      Btn_step = 0;
      tick();
      chk("step_busy", Busy, 1);
      tick();
      chk("step_idle", Busy, 0);
      chk("step_sel", Step_sel, (i + 1) % 4);
    end
    chk("step_no_valid", vld_cnt, snap);

    // 5. saturation at both ends
    for (int i = 0; i < 7; i++) op(3);
    chk("down7_freq", Freq_word, 357);
    op(3);
    chk("down_clamp_min", Freq_word, 179);
    snap = vld_cnt;
    op(3);
    chk("down_at_min", Freq_word, 179);
    chk("down_at_min_sent", vld_cnt, snap + 1);
    for (int i = 0; i < 3; i++) op(1);
    chk("step3_sel", Step_sel, 3);
    for (int i = 0; i < 999; i++) op(2);
    chk("up999_freq", Freq_word, 178778222);
    op(2);
    chk("up_clamp_max", Freq_word, FMAX);
    op(2);
    chk("up_at_max", Freq_word, FMAX);
    op(1);
    chk("step_wrap", Step_sel, 0);
    op(3);
    chk("down_near_max", Freq_word, FMAX - 32'd179);
    op(2);
    chk("up_exact_max", Freq_word, FMAX);

    // 6. reset while SEND is stalled with requests pending
    Cfg_ready = 0;
    Btn_up = 1;
    tick();
    Btn_up = 0;
    tick();
    tick();
    chk("r6_in_send", Cfg_valid, 1);
    Btn_wave = 1; Btn_down = 1;
    tick();
    Btn_wave = 0; Btn_down = 0;
    #2;
    Resetn = 0;
    #1;
    chk("r6_valid_drop", Cfg_valid, 0);
    chk("r6_busy", Busy, 1);
    chk("r6_freq", Freq_word, 1789);
    chk("r6_wave", Wave_sel, 0);
    Cfg_ready = 1;
    tick();
    Resetn = 1;
    tick();
    chk("r6_resend_valid", Cfg_valid, 1);
    chk("r6_resend_freq", Freq_word, 1789);
    tick();
    chk("r6_idle", Busy, 0);
    snap = vld_cnt;
    held = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Busy) held = 0;
    end
    chk("r6_no_pending", held, 1);
    chk("r6_no_send", vld_cnt, snap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
